lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Memory-access pipeline stage sitting directly after the execute stage; it is the consumer of execute-stage results.
- Latches one execute-stage bundle per handshake. For a load or store it drives a single-outstanding valid/ready data-memory transaction; otherwise it passes EX_result through.
- Presents a writeback bundle to the writeback stage.
- Handles byte-lane steering, write strobes, load sign/zero extension and misalignment detection.

Parameters:
- AW, 32, data-memory address width.
- DW, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  execute bundle valid
- in_ready  out  1  stage can accept a bundle
- pc  in  32  instruction PC (pass-through)
- ex_result  in  32  ALU result; effective address for memory ops
- rs2_value  in  32  store data
- funct3  in  3  access size/sign
- rd  in  5  destination register
- r_wen  in  1  register write enable
- mem_wen  in  1  store
- mem_ren  in  1  load
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  AW  word-aligned address ({addr[31:2],2'b00})
- dmem_wen  out  1  1 = write
- dmem_wdata  out  32  lane-shifted store data
- dmem_wstrb  out  4  byte strobes
- dmem_resp_valid  in  1  response valid (read data or write done)
- dmem_rdata  in  32  read word
- out_valid  out  1  writeback bundle valid
- out_ready  in  1  writeback accepts
- out_pc  out  32  PC
- out_rd  out  5  rd
- out_r_wen  out  1  register write enable
- out_wb_data  out  32  load data or ex_result
- misalign  out  1  one-cycle pulse with out_valid on a misaligned access

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - State goes to IDLE.
  - All outputs 0, except in_ready = 1.
  - Any in-flight request is abandoned. A dmem response arriving after reset is ignored.
- Accept: when in_valid && in_ready, the bundle is registered.
  - in_ready = 1 only in IDLE, or in DONE when out_ready = 1 that cycle. Back-to-back operation at 1 op/cycle is allowed for non-memory ops.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE --accept, memory op, aligned--> REQ.
  - IDLE --accept, non-memory op or misaligned--> DONE.
  - REQ: dmem_req_valid = 1 and address/wdata/wstrb held stable. On dmem_req_ready --> WAIT.
  - WAIT: on dmem_resp_valid, capture the extended data and go to DONE.
    - A response arriving in the same cycle as req_ready is not legal. Memory latency is at least 1 cycle after acceptance.
  - DONE: out_valid = 1 with outputs held stable. On out_ready, go to IDLE, or to the next state directly if a new bundle is accepted the same cycle.
- Latency: non-memory op has out_valid 1 cycle after accept. Memory op has out_valid 1 cycle after dmem_resp_valid.
- Store encoding (mem_wen): funct3 000 = SB, 001 = SH, 010 = SW.
  - wstrb: SB = 0001 << a[1:0]; SH = 0011 << a[1:0]; SW = 1111.
  - wdata: SB = {4{rs2[7:0]}}; SH = {2{rs2[15:0]}}; SW = rs2.
  - out_r_wen is forced to 0 for stores.
- Load encoding (mem_ren): funct3 000 = LB, 001 = LH, 010 = LW, 100 = LBU, 101 = LHU.
  - The byte/half is selected by a[1:0] and sign- or zero-extended.
  - wstrb = 0 for loads.
- Misaligned access (half with a[0] = 1, or word with a[1:0] != 0):
  - No dmem request is issued.
  - DONE with misalign = 1, out_r_wen = 0, out_wb_data = ex_result.
- Unsupported funct3 on a memory op is treated as the word size.
- mem_wen && mem_ren both 1: the store takes priority.
- Non-memory op: out_wb_data = ex_result and out_r_wen = r_wen.
- out_r_wen is forced to 0 when rd = 0.

Decomposition:
- Shared package/defines: funct3 codes (LB/LH/LW/LBU/LHU, SB/SH/SW) and FSM state encodings (2-bit).
- One sub-module, lsu_lane_align: combinational store steering (wdata/wstrb) plus load extraction/extension.

Test Plan:
- ALU op: ex_result = 0x1234, r_wen = 1, rd = 5 -> out_valid 1 cycle later, out_wb_data = 0x1234, no dmem_req_valid.
- SB: addr = 0x1003, rs2 = 0xAB -> dmem_addr = 0x1000, wstrb = 1000, wdata = 0xABABABAB; req held 3 cycles while req_ready = 0; out_r_wen = 0 after resp.
- LB vs LBU: addr = 0x2002, rdata = 0x00800000 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- LW at addr 0x3002 -> no request; misalign pulses with out_valid; out_r_wen = 0.
- Back-pressure: out_ready = 0 for 4 cycles -> outputs stable and in_ready = 0; next bundle accepted in the cycle out_ready rises.
- Reset asserted in WAIT -> next cycle IDLE and outputs 0; a late dmem_resp_valid produces no out_valid.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM states
// and access-size decode helpers used by both the stage and its lane aligner.
package lsu_mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Any funct3 that is not a recognised byte/half code falls back to word size.
  function automatic size_t accessSize(input logic isStore, input logic [2:0] f3);
    size_t sz;
    sz = SZ_WORD;
    if (isStore) begin
      if (f3 == F3_SB) sz = SZ_BYTE;
      else if (f3 == F3_SH) sz = SZ_HALF;
    end else begin
      if (f3 == F3_LB || f3 == F3_LBU) sz = SZ_BYTE;
      else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_HALF;
    end
    return sz;
  endfunction

  function automatic logic isMisaligned(input size_t sz, input logic [1:0] addrLo);
    logic mis;
    mis = 1'b0;
    if (sz == SZ_HALF) mis = addrLo[0];
    else if (sz == SZ_WORD) mis = (addrLo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store data replication and strobes, plus
// load byte/half extraction with sign or zero extension.
module lsu_lane_align
  import lsu_mem_stage_pkg::*;
(
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addrLo,
  input  logic [31:0] i_storeData,
  input  logic [31:0] i_loadWord,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_loadData,
  output logic        o_misalign
);

  size_t       w_size;
  logic [31:0] w_shifted;
  logic        w_unsigned;

  assign w_size     = accessSize(i_store, i_funct3);
  assign w_shifted  = i_loadWord >> {i_addrLo, 3'b000};
  assign w_unsigned = i_funct3[2];
  assign o_misalign = isMisaligned(w_size, i_addrLo);

  // Stores replicate the datum into every lane; the strobe picks the real lane.
  always_comb begin
    o_wdata = 32'd0;
    o_wstrb = 4'b0000;
    if (i_store) begin
      case (w_size)
        SZ_BYTE: begin
          o_wdata = {4{i_storeData[7:0]}};
          o_wstrb = 4'b0001 << i_addrLo;
        end
        SZ_HALF: begin
          o_wdata = {2{i_storeData[15:0]}};
          o_wstrb = 4'b0011 << i_addrLo;
        end
        default: begin
          o_wdata = i_storeData;
          o_wstrb = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    o_loadData = i_loadWord;
    case (w_size)
      SZ_BYTE: o_loadData = w_unsigned ? {24'd0, w_shifted[7:0]}
                                       : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_loadData = w_unsigned ? {16'd0, w_shifted[15:0]}
                                       : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: o_loadData = i_loadWord;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access pipeline stage: latches one execute bundle, runs a single
// outstanding data-memory transaction for loads/stores, presents writeback.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   pc,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] rs2_value,
  input  logic [2:0]    funct3,
  input  logic [4:0]    rd,
  input  logic          r_wen,
  input  logic          mem_wen,
  input  logic          mem_ren,
  output logic          dmem_req_valid,
  input  logic          dmem_req_ready,
  output logic [AW-1:0] dmem_addr,
  output logic          dmem_wen,
  output logic [DW-1:0] dmem_wdata,
  output logic [3:0]    dmem_wstrb,
  input  logic          dmem_resp_valid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [4:0]    out_rd,
  output logic          out_r_wen,
  output logic [DW-1:0] out_wb_data,
  output logic          misalign
);

  state_t r_state, w_nextState, w_bundleState;

  logic [31:0]   r_pc;
  logic [4:0]    r_rd;
  logic          r_rwen;
  logic [DW-1:0] r_wbData;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_wstrb;
  logic          r_dmemWen;
  logic          r_isStore;
  logic [2:0]    r_funct3;
  logic [1:0]    r_addrLo;
  logic          r_misalign;

  logic          w_accept;
  logic          w_isStore;
  logic          w_isMem;
  logic          w_misalign;
  logic          w_laneStore;
  logic [2:0]    w_laneFunct3;
  logic [1:0]    w_laneAddrLo;
  logic [31:0]   w_laneWdata;
  logic [3:0]    w_laneWstrb;
  logic [31:0]   w_loadData;
  logic          w_laneMis;

  assign w_isStore  = mem_wen;
  assign w_isMem    = mem_wen | mem_ren;
  assign w_misalign = w_isMem & w_laneMis;

  // One aligner serves both directions: it decodes the incoming bundle except
  // while waiting for read data, when it extracts from the returned word.
  assign w_laneStore  = (r_state == ST_WAIT) ? r_isStore : w_isStore;
  assign w_laneFunct3 = (r_state == ST_WAIT) ? r_funct3  : funct3;
  assign w_laneAddrLo = (r_state == ST_WAIT) ? r_addrLo  : ex_result[1:0];

  lsu_lane_align u_laneAlign (
    .i_store     (w_laneStore),
    .i_funct3    (w_laneFunct3),
    .i_addrLo    (w_laneAddrLo),
    .i_storeData (rs2_value),
    .i_loadWord  (dmem_rdata),
    .o_wdata     (w_laneWdata),
    .o_wstrb     (w_laneWstrb),
    .o_loadData  (w_loadData),
    .o_misalign  (w_laneMis)
  );

  assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_bundleState = (w_isMem && !w_misalign) ? ST_REQ : ST_DONE;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_nextState = w_bundleState;
      ST_REQ:  if (dmem_req_ready) w_nextState = ST_WAIT;
      ST_WAIT: if (dmem_resp_valid) w_nextState = ST_DONE;
      ST_DONE: if (out_ready) w_nextState = w_accept ? w_bundleState : ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Register write is suppressed for stores, faulting accesses and x0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_rd       <= '0;
      r_rwen     <= 1'b0;
      r_wbData   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_dmemWen  <= 1'b0;
      r_isStore  <= 1'b0;
      r_funct3   <= '0;
      r_addrLo   <= '0;
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_pc       <= pc;
      r_rd       <= rd;
      r_rwen     <= r_wen && (rd != 5'd0) && !w_isStore && !w_misalign;
      r_wbData   <= ex_result;
      r_addr     <= {ex_result[AW-1:2], 2'b00};
      r_wdata    <= w_isStore ? w_laneWdata : '0;
      r_wstrb    <= (w_isMem && !w_misalign) ? w_laneWstrb : 4'b0000;
      r_dmemWen  <= w_isStore;
      r_isStore  <= w_isStore;
      r_funct3   <= funct3;
      r_addrLo   <= ex_result[1:0];
      r_misalign <= w_misalign;
    end else if ((r_state == ST_WAIT) && dmem_resp_valid && !r_isStore) begin
      r_wbData   <= w_loadData;
    end
  end

  assign dmem_req_valid = (r_state == ST_REQ);
  assign dmem_addr      = r_addr;
  assign dmem_wen       = r_dmemWen;
  assign dmem_wdata     = r_wdata;
  assign dmem_wstrb     = r_wstrb;
  assign out_valid      = (r_state == ST_DONE);
  assign out_pc         = r_pc;
  assign out_rd         = r_rd;
  assign out_r_wen      = r_rwen;
  assign out_wb_data    = r_wbData;
  assign misalign       = out_valid && r_misalign;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a vector table of single operations plus
// hand-written sequences for stalls, back-pressure and reset mid-transaction.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] pc, ex_result, rs2_value;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        r_wen, mem_wen, mem_ren;
  logic        dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_wen;
  logic [3:0]  dmem_wstrb;
  logic        dmem_resp_valid;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_wb_data;
  logic [4:0]  out_rd;
  logic        out_r_wen, misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .ex_result(ex_result), .rs2_value(rs2_value),
    .funct3(funct3), .rd(rd), .r_wen(r_wen),
    .mem_wen(mem_wen), .mem_ren(mem_ren),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_r_wen(out_r_wen),
    .out_wb_data(out_wb_data), .misalign(misalign)
  );

  typedef struct {
    string       name;
    logic [31:0] pc, ex, rs2;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rwen, wen, ren;
    logic [31:0] rdata;
    logic        expReq;
    logic [31:0] expAddr;
    logic [3:0]  expWstrb;
    logic [31:0] expWdata, expWb;
    logic        expRwen, expMis;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveBundle(input logic [31:0] p, input logic [31:0] ex, input logic [31:0] rs2,
                             input logic [2:0] f3, input logic [4:0] d, input logic rw,
                             input logic w, input logic r);
    in_valid = 1'b1; pc = p; ex_result = ex; rs2_value = rs2;
    funct3 = f3; rd = d; r_wen = rw; mem_wen = w; mem_ren = r;
  endtask

  // Called at a falling edge with the stage idle; returns idle again.
  task automatic applyStimulus(input vec_t v);
    driveBundle(v.pc, v.ex, v.rs2, v.f3, v.rd, v.rwen, v.wen, v.ren);
    @(negedge clk);
    in_valid = 1'b0;
    if (v.expReq) begin
      checkOutput({v.name, ".reqValid"}, dmem_req_valid, 1);
      checkOutput({v.name, ".addr"}, dmem_addr, v.expAddr);
      checkOutput({v.name, ".wstrb"}, dmem_wstrb, v.expWstrb);
      checkOutput({v.name, ".wen"}, dmem_wen, v.wen);
      if (v.wen) checkOutput({v.name, ".wdata"}, dmem_wdata, v.expWdata);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      checkOutput({v.name, ".reqDrop"}, dmem_req_valid, 0);
      checkOutput({v.name, ".earlyOut"}, out_valid, 0);
      dmem_resp_valid = 1'b1;
      dmem_rdata = v.rdata;
      @(negedge clk);
      dmem_resp_valid = 1'b0;
    end else begin
      checkOutput({v.name, ".noReq"}, dmem_req_valid, 0);
    end
    checkOutput({v.name, ".outValid"}, out_valid, 1);
    checkOutput({v.name, ".wbData"}, out_wb_data, v.expWb);
    checkOutput({v.name, ".rwen"}, out_r_wen, v.expRwen);
    checkOutput({v.name, ".rd"}, out_rd, v.rd);
    checkOutput({v.name, ".pc"}, out_pc, v.pc);
    checkOutput({v.name, ".misalign"}, misalign, v.expMis);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({v.name, ".drained"}, out_valid, 0);
    checkOutput({v.name, ".misDrop"}, misalign, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //           name     pc        ex            rs2           f3      rd     rw   w    r    rdata         req  addr          strb     wdata         wb            rwen mis
    vecs[0]  = '{"alu",   32'h100, 32'h00001234, 32'h0,        3'b000, 5'd5,  1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        4'b0000, 32'h0,        32'h00001234, 1'b1,1'b0};
    vecs[1]  = '{"sb",    32'h104, 32'h00001003, 32'h000000AB, 3'b000, 5'd4,  1'b1,1'b1,1'b0,32'h0,        1'b1,32'h00001000, 4'b1000, 32'hABABABAB, 32'h00001003, 1'b0,1'b0};
    vecs[2]  = '{"lb",    32'h108, 32'h00002002, 32'h0,        3'b000, 5'd7,  1'b1,1'b0,1'b1,32'h00800000, 1'b1,32'h00002000, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b1,1'b0};
    vecs[3]  = '{"lbu",   32'h10C, 32'h00002002, 32'h0,        3'b100, 5'd7,  1'b1,1'b0,1'b1,32'h00800000, 1'b1,32'h00002000, 4'b0000, 32'h0,        32'h00000080, 1'b1,1'b0};
    vecs[4]  = '{"lwMis", 32'h110, 32'h00003002, 32'h0,        3'b010, 5'd8,  1'b1,1'b0,1'b1,32'h0,        1'b0,32'h0,        4'b0000, 32'h0,        32'h00003002, 1'b0,1'b1};
    vecs[5]  = '{"sh",    32'h114, 32'h00001002, 32'h1234CDEF, 3'b001, 5'd0,  1'b0,1'b1,1'b0,32'h0,        1'b1,32'h00001000, 4'b1100, 32'hCDEFCDEF, 32'h00001002, 1'b0,1'b0};
    vecs[6]  = '{"sw",    32'h118, 32'h00001004, 32'hDEADBEEF, 3'b010, 5'd9,  1'b1,1'b1,1'b0,32'h0,        1'b1,32'h00001004, 4'b1111, 32'hDEADBEEF, 32'h00001004, 1'b0,1'b0};
    vecs[7]  = '{"lh",    32'h11C, 32'h00004002, 32'h0,        3'b001, 5'd10, 1'b1,1'b0,1'b1,32'h80011234, 1'b1,32'h00004000, 4'b0000, 32'h0,        32'hFFFF8001, 1'b1,1'b0};
    vecs[8]  = '{"lhu",   32'h120, 32'h00004000, 32'h0,        3'b101, 5'd11, 1'b1,1'b0,1'b1,32'h8001F234, 1'b1,32'h00004000, 4'b0000, 32'h0,        32'h0000F234, 1'b1,1'b0};
    vecs[9]  = '{"lw",    32'h124, 32'h00004008, 32'h0,        3'b010, 5'd3,  1'b1,1'b0,1'b1,32'hCAFEBABE, 1'b1,32'h00004008, 4'b0000, 32'h0,        32'hCAFEBABE, 1'b1,1'b0};
    vecs[10] = '{"lbX0",  32'h128, 32'h00002001, 32'h0,        3'b000, 5'd0,  1'b1,1'b0,1'b1,32'h00007F00, 1'b1,32'h00002000, 4'b0000, 32'h0,        32'h0000007F, 1'b0,1'b0};
    vecs[11] = '{"shMis", 32'h12C, 32'h00001001, 32'h00005555, 3'b001, 5'd0,  1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        4'b0000, 32'h0,        32'h00001001, 1'b0,1'b1};
    vecs[12] = '{"aluNoW",32'h130, 32'h0000BEEF, 32'h0,        3'b000, 5'd12, 1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        4'b0000, 32'h0,        32'h0000BEEF, 1'b0,1'b0};
    vecs[13] = '{"bothSB",32'h134, 32'h00001000, 32'h00000055, 3'b000, 5'd13, 1'b1,1'b1,1'b1,32'h0,        1'b1,32'h00001000, 4'b0001, 32'h55555555, 32'h00001000, 1'b0,1'b0};
    vecs[14] = '{"ld011", 32'h138, 32'h00005000, 32'h0,        3'b011, 5'd14, 1'b1,1'b0,1'b1,32'h11223344, 1'b1,32'h00005000, 4'b0000, 32'h0,        32'h11223344, 1'b1,1'b0};

    rst_n = 1'b0; in_valid = 1'b0; pc = '0; ex_result = '0; rs2_value = '0;
    funct3 = '0; rd = '0; r_wen = 1'b0; mem_wen = 1'b0; mem_ren = 1'b0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst.inReady", in_ready, 1);
    checkOutput("rst.outValid", out_valid, 0);
    checkOutput("rst.reqValid", dmem_req_valid, 0);
    checkOutput("rst.addr", dmem_addr, 0);
    checkOutput("rst.wstrb", dmem_wstrb, 0);
    checkOutput("rst.wbData", out_wb_data, 0);
    checkOutput("rst.misalign", misalign, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

    // SB stalled by the memory for three cycles
    driveBundle(32'h200, 32'h00001003, 32'h000000AB, 3'b000, 5'd4, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall.reqValid", dmem_req_valid, 1);
      checkOutput("stall.addr", dmem_addr, 32'h00001000);
      checkOutput("stall.wstrb", dmem_wstrb, 4'b1000);
      checkOutput("stall.wdata", dmem_wdata, 32'hABABABAB);
      @(negedge clk);
    end
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b1;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    checkOutput("stall.outValid", out_valid, 1);
    checkOutput("stall.rwen", out_r_wen, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Writeback back-pressure, then a new bundle accepted as out_ready rises
    driveBundle(32'h300, 32'h00001234, 32'h0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp.outValid", out_valid, 1);
      checkOutput("bp.wbData", out_wb_data, 32'h00001234);
      checkOutput("bp.inReady", in_ready, 0);
      @(negedge clk);
    end
    driveBundle(32'h304, 32'h0000BEEF, 32'h0, 3'b000, 5'd6, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    checkOutput("bp.inReadyRise", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("bp.nextValid", out_valid, 1);
    checkOutput("bp.nextWb", out_wb_data, 32'h0000BEEF);
    checkOutput("bp.nextRd", out_rd, 6);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while waiting for a load response; the late response is dropped
    driveBundle(32'h400, 32'h00006000, 32'h0, 3'b010, 5'd2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rstWait.inReady", in_ready, 1);
    checkOutput("rstWait.outValid", out_valid, 0);
    checkOutput("rstWait.reqValid", dmem_req_valid, 0);
    checkOutput("rstWait.addr", dmem_addr, 0);
    checkOutput("rstWait.wbData", out_wb_data, 0);
    rst_n = 1'b1;
    dmem_resp_valid = 1'b1;
    dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    checkOutput("rstWait.lateResp", out_valid, 0);
    @(negedge clk);
    checkOutput("rstWait.stillIdle", out_valid, 0);
    checkOutput("rstWait.wbClear", out_wb_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
